pmu_dump_sequencer: RTL and testbench



---
 rtl/pmu_dump_pkg.sv | 23 ++
 rtl/pmu_dump_sequencer_if.sv | 10 +
 rtl/pmu_dump_sequencer_byte_serializer_32.sv | 69 ++++++
 rtl/pmu_dump_sequencer.sv | 207 ++++++++++++++++++++
 tb/tb_pmu_dump_sequencer.sv | 252 +++++++++++++++++++++++++
 5 files changed

// File: rtl/pmu_dump_pkg.sv
// Shared types and constants for the PMU dump path; also consumed by the UART
// control block when it decodes the "dump" command.
package pmu_dump_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        HEADER    = 3'd1,
        SET_ADDR  = 3'd2,
        WAIT_DATA = 3'd3,
        SEND      = 3'd4,
        CHECKSUM  = 3'd5
    } dump_state_t;

    localparam logic [7:0] DEFAULT_HEADER_BYTE = 8'hA5;
    localparam int         PMU_ADDR_W          = 5;
    localparam int         PMU_WORD_W          = 32;

    // Running XOR checksum step over one payload byte.
    function automatic logic [7:0] xor_accum(input logic [7:0] acc, input logic [7:0] b);
        return acc ^ b;
    endfunction

endpackage

// File: rtl/pmu_dump_sequencer_if.sv
// Byte stream toward the UART transmitter: data/valid from the sequencer,
// ready back from the transmitter.
interface pmu_dump_stream_if;
    logic [7:0] data;
    logic       valid;
    logic       ready;

    modport master (output data, output valid, input ready);
    modport slave  (input data, input valid, output ready);
endinterface

// File: rtl/pmu_dump_sequencer_byte_serializer_32.sv
// Holds one 32-bit counter sample and emits it as four bytes, LSB first,
// with a valid/ready handshake and a last-byte flag.
module byte_serializer_32 (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        clear_i,
    input  logic        load_i,
    input  logic [31:0] word_i,
    input  logic        ready_i,
    output logic [7:0]  byte_o,
    output logic        valid_o,
    output logic        last_o
);
    logic [31:0] word_q, word_d;
    logic [1:0]  cnt_q, cnt_d;
    logic        valid_q, valid_d;

    // Next-state for the holding word, byte index and valid flag.
    always_comb begin
        word_d  = word_q;
        cnt_d   = cnt_q;
        valid_d = valid_q;
        if (clear_i) begin
            valid_d = 1'b0;
            cnt_d   = 2'd0;
        end else if (load_i) begin
            word_d  = word_i;
            cnt_d   = 2'd0;
            valid_d = 1'b1;
        end else if (valid_q && ready_i) begin
            if (cnt_q == 2'd3) begin
                valid_d = 1'b0;
                cnt_d   = 2'd0;
            end else begin
                cnt_d = cnt_q + 2'd1;
            end
        end else begin
            valid_d = valid_q;
        end
    end

    // Serializer state registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            word_q  <= 32'h0000_0000;
            cnt_q   <= 2'd0;
            valid_q <= 1'b0;
        end else begin
            word_q  <= word_d;
            cnt_q   <= cnt_d;
            valid_q <= valid_d;
        end
    end

    // Byte lane select from the held word.
    always_comb begin
        case (cnt_q)
            2'd0:    byte_o = word_q[7:0];
            2'd1:    byte_o = word_q[15:8];
            2'd2:    byte_o = word_q[23:16];
            2'd3:    byte_o = word_q[31:24];
            default: byte_o = 8'h00;
        endcase
    end

    assign valid_o = valid_q;
    assign last_o  = (cnt_q == 2'd3);

endmodule

// File: rtl/pmu_dump_sequencer.sv
// Walks every (core, metric) PMU counter and streams them as one framed burst:
// header, 4 bytes per counter LSB first, XOR checksum of the payload.
module pmu_dump_sequencer
    import pmu_dump_pkg::*;
#(
    parameter int         CORE_COUNT   = 16,
    parameter int         METRIC_COUNT = 8,
    parameter int         PMU_LAT      = 1,
    parameter logic [7:0] HEADER_BYTE  = DEFAULT_HEADER_BYTE
) (
    input  logic                                    clk_i,
    input  logic                                    rst_i,
    input  logic                                    start_i,
    input  logic                                    abort_i,
    output logic                                    busy_o,
    output logic                                    done_o,
    output logic [CORE_COUNT-1:0][PMU_ADDR_W-1:0]   pmu_addr_o,
    input  logic [CORE_COUNT-1:0][PMU_WORD_W-1:0]   pmu_data_i,
    pmu_dump_stream_if.master                       tx_if
);
    localparam int                   CORE_W      = (CORE_COUNT > 1) ? $clog2(CORE_COUNT) : 1;
    localparam logic [CORE_W-1:0]    LAST_CORE   = CORE_W'(CORE_COUNT - 1);
    localparam logic [PMU_ADDR_W-1:0] LAST_METRIC = PMU_ADDR_W'(METRIC_COUNT - 1);
    localparam logic [2:0]           LAT_INIT    = 3'(PMU_LAT);

    dump_state_t               state_q, state_d;
    logic [CORE_W-1:0]         core_q, core_d;
    logic [PMU_ADDR_W-1:0]     metric_q, metric_d;
    logic [PMU_ADDR_W-1:0]     addr_q, addr_d;
    logic [2:0]                lat_q, lat_d;
    logic [7:0]                checksum_q, checksum_d;
    logic [7:0]                ctl_byte_q, ctl_byte_d;
    logic                      ctl_valid_q, ctl_valid_d;
    logic                      busy_q, busy_d;
    logic                      done_q, done_d;

    logic                      ser_load_s;
    logic                      ser_clear_s;
    logic [7:0]                ser_byte_s;
    logic                      ser_valid_s;
    logic                      ser_last_s;
    logic                      ser_fire_s;
    logic                      ctl_fire_s;

    byte_serializer_32 u_ser (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .clear_i (ser_clear_s),
        .load_i  (ser_load_s),
        .word_i  (pmu_data_i[core_q]),
        .ready_i (tx_if.ready),
        .byte_o  (ser_byte_s),
        .valid_o (ser_valid_s),
        .last_o  (ser_last_s)
    );

    assign ser_fire_s = (state_q == SEND) && ser_valid_s && tx_if.ready;
    assign ctl_fire_s = ctl_valid_q && tx_if.ready;

    // Frame sequencing: next state, counters and control outputs.
    always_comb begin
        state_d     = state_q;
        core_d      = core_q;
        metric_d    = metric_q;
        addr_d      = addr_q;
        lat_d       = lat_q;
        checksum_d  = checksum_q;
        ctl_byte_d  = ctl_byte_q;
        ctl_valid_d = ctl_valid_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        ser_load_s  = 1'b0;
        ser_clear_s = 1'b0;

        case (state_q)
            IDLE: begin
                if (start_i && !abort_i) begin
                    state_d     = HEADER;
                    busy_d      = 1'b1;
                    checksum_d  = 8'h00;
                    core_d      = '0;
                    metric_d    = '0;
                    ctl_byte_d  = HEADER_BYTE;
                    ctl_valid_d = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
            HEADER: begin
                if (ctl_fire_s) begin
                    ctl_valid_d = 1'b0;
                    state_d     = SET_ADDR;
                end else begin
                    state_d = HEADER;
                end
            end
            SET_ADDR: begin
                addr_d  = metric_q;
                lat_d   = LAT_INIT;
                state_d = WAIT_DATA;
            end
            WAIT_DATA: begin
                lat_d = lat_q - 3'd1;
                if (lat_q == 3'd1) begin
                    ser_load_s = 1'b1;
                    state_d    = SEND;
                end else begin
                    state_d = WAIT_DATA;
                end
            end
            SEND: begin
                if (ser_fire_s) begin
                    checksum_d = xor_accum(checksum_q, ser_byte_s);
                    if (ser_last_s) begin
                        if (metric_q == LAST_METRIC) begin
                            metric_d = '0;
                            if (core_q == LAST_CORE) begin
                                core_d      = '0;
                                ctl_byte_d  = xor_accum(checksum_q, ser_byte_s);
                                ctl_valid_d = 1'b1;
                                state_d     = CHECKSUM;
                            end else begin
                                core_d  = core_q + CORE_W'(1);
                                state_d = SET_ADDR;
                            end
                        end else begin
                            metric_d = metric_q + 5'd1;
                            state_d  = SET_ADDR;
                        end
                    end else begin
                        state_d = SEND;
                    end
                end else begin
                    state_d = SEND;
                end
            end
            CHECKSUM: begin
                if (ctl_fire_s) begin
                    ctl_valid_d = 1'b0;
                    ctl_byte_d  = 8'h00;
                    done_d      = 1'b1;
                    busy_d      = 1'b0;
                    state_d     = IDLE;
                end else begin
                    state_d = CHECKSUM;
                end
            end
            default: begin
                state_d     = IDLE;
                busy_d      = 1'b0;
                ctl_valid_d = 1'b0;
            end
        endcase

        // Abort wins over every transition; the address bus is left where it was.
        if (abort_i && (state_q != IDLE)) begin
            state_d     = IDLE;
            busy_d      = 1'b0;
            done_d      = 1'b0;
            ctl_valid_d = 1'b0;
            ctl_byte_d  = 8'h00;
            addr_d      = addr_q;
            core_d      = core_q;
            metric_d    = metric_q;
            lat_d       = lat_q;
            checksum_d  = checksum_q;
            ser_load_s  = 1'b0;
            ser_clear_s = 1'b1;
        end else begin
            ser_clear_s = 1'b0;
        end
    end

    // Sequencer state registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            core_q      <= '0;
            metric_q    <= '0;
            addr_q      <= '0;
            lat_q       <= 3'd0;
            checksum_q  <= 8'h00;
            ctl_byte_q  <= 8'h00;
            ctl_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            core_q      <= core_d;
            metric_q    <= metric_d;
            addr_q      <= addr_d;
            lat_q       <= lat_d;
            checksum_q  <= checksum_d;
            ctl_byte_q  <= ctl_byte_d;
            ctl_valid_q <= ctl_valid_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign busy_o      = busy_q;
    assign done_o      = done_q;
    assign pmu_addr_o  = {CORE_COUNT{addr_q}};
    assign tx_if.data  = (state_q == SEND) ? ser_byte_s  : ctl_byte_q;
    assign tx_if.valid = (state_q == SEND) ? ser_valid_s : ctl_valid_q;

endmodule

// File: tb/tb_pmu_dump_sequencer.sv
// Scoreboard bench: expected frame bytes are queued when a dump is started and
// popped as the sequencer hands bytes to the (modelled) transmitter.
module tb_pmu_dump_sequencer;
    import pmu_dump_pkg::*;

    localparam int CC  = 2;
    localparam int MC  = 2;
    localparam int LAT = 3;

    logic                        clk = 1'b0;
    logic                        rst;
    logic                        start;
    logic                        abort;
    logic                        busy;
    logic                        done;
    logic [CC-1:0][PMU_ADDR_W-1:0] pmu_addr;
    logic [CC-1:0][31:0]         pmu_data;
    logic [CC-1:0][PMU_ADDR_W-1:0] addr_dly;
    logic [7:0]                  salt;

    pmu_dump_stream_if tx ();

    pmu_dump_sequencer #(
        .CORE_COUNT   (CC),
        .METRIC_COUNT (MC),
        .PMU_LAT      (LAT),
        .HEADER_BYTE  (8'hA5)
    ) dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .start_i    (start),
        .abort_i    (abort),
        .busy_o     (busy),
        .done_o     (done),
        .pmu_addr_o (pmu_addr),
        .pmu_data_i (pmu_data),
        .tx_if      (tx)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int nbytes = 0;
    int ndone  = 0;
    int ready_mode = 0;
    int rcnt = 0;
    logic [7:0] exp_q[$];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h, want %0h", tag, got, exp);
        end
    endtask

    // Counter value of core c, metric m; salt 0 gives 32'h0C0D_0000 | c<<8 | m.
    function automatic logic [31:0] pmu_word(input int c, input int m, input logic [7:0] s);
        logic [7:0] b3;
        b3 = 8'h0C ^ 8'(int'(s) * (c * MC + m + 1));
        return {b3, 8'h0D, 8'(c), 8'(m) ^ s};
    endfunction

    // PMU model: data follows the address one cycle late.
    always @(posedge clk) addr_dly <= pmu_addr;

    always_comb begin
        for (int c = 0; c < CC; c++) pmu_data[c] = pmu_word(c, int'(addr_dly[c]), salt);
    end

    always @(posedge clk) begin
        #1;
        if (ready_mode == 1) begin
            rcnt++;
            tx.ready = ((rcnt % 3) == 0);
        end else begin
            tx.ready = 1'b1;
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            if (tx.valid && !tx.ready && exp_q.size() != 0)
                check_eq("stall_data", {24'h0, tx.data}, {24'h0, exp_q[0]});
            if (tx.valid && tx.ready) begin
                check_eq("byte_expected", 32'(exp_q.size() != 0), 32'd1);
                if (exp_q.size() != 0) check_eq("stream_byte", {24'h0, tx.data}, {24'h0, exp_q.pop_front()});
                nbytes++;
            end
            if (done) ndone++;
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push_frame(input logic [7:0] s);
        logic [7:0] cks;
        logic [31:0] w;
        logic [7:0] b;
        cks = 8'h00;
        exp_q.push_back(8'hA5);
        for (int c = 0; c < CC; c++) begin
            for (int m = 0; m < MC; m++) begin
                w = pmu_word(c, m, s);
                for (int k = 0; k < 4; k++) begin
                    b = w[8*k +: 8];
                    exp_q.push_back(b);
                    cks = cks ^ b;
                end
            end
        end
        exp_q.push_back(cks);
    endtask

    task automatic wait_bytes(input int n, input int budget);
        int k;
        k = 0;
        while (nbytes < n && k < budget) begin
            @(posedge clk);
            k++;
        end
        #1;
        check_eq("bytes_reached", 32'(nbytes >= n), 32'd1);
    endtask

    task automatic run_frame(input logic [7:0] s, input int budget, input int restart_at);
        int base;
        int k;
        salt = s;
        push_frame(s);
        nbytes = 0;
        base = ndone;
        start = 1'b1;
        cyc(1);
        start = 1'b0;
        check_eq("busy_rise", 32'(busy), 32'd1);
        if (restart_at > 0) begin
            cyc(restart_at);
            start = 1'b1;
            cyc(1);
            start = 1'b0;
        end
        k = 0;
        while (ndone == base && k < budget) begin
            @(posedge clk);
            k++;
        end
        #1;
        check_eq("done_seen", 32'(ndone - base), 32'd1);
        check_eq("done_pulse", 32'(done), 32'd0);
        check_eq("busy_fall", 32'(busy), 32'd0);
        check_eq("frame_len", 32'(nbytes), 32'(2 + 4 * CC * MC));
        check_eq("queue_empty", 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int base;
        rst = 1'b1;
        start = 1'b0;
        abort = 1'b0;
        salt = 8'h00;
        tx.ready = 1'b1;
        cyc(3);
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_done", 32'(done), 32'd0);
        check_eq("rst_valid", 32'(tx.valid), 32'd0);
        check_eq("rst_data", {24'h0, tx.data}, 32'd0);
        check_eq("rst_addr", 32'(pmu_addr), 32'd0);
        rst = 1'b0;
        cyc(2);

        // Plain frame, then the same frame under 1-in-3 backpressure.
        run_frame(8'h00, 200, 0);
        cyc(3);
        ready_mode = 1;
        run_frame(8'h00, 600, 0);
        ready_mode = 0;
        cyc(3);

        // Abort while the second payload byte is on the bus.
        salt = 8'h05;
        push_frame(8'h05);
        nbytes = 0;
        base = ndone;
        start = 1'b1;
        cyc(1);
        start = 1'b0;
        wait_bytes(2, 60);
        abort = 1'b1;
        cyc(1);
        abort = 1'b0;
        check_eq("abort_valid", 32'(tx.valid), 32'd0);
        check_eq("abort_busy", 32'(busy), 32'd0);
        exp_q.delete();
        cyc(6);
        check_eq("abort_no_done", 32'(ndone - base), 32'd0);
        run_frame(8'h05, 200, 0);
        cyc(3);

        // Start re-pulsed mid-frame is ignored.
        base = ndone;
        run_frame(8'h09, 200, 10);
        cyc(40);
        check_eq("single_frame", 32'(ndone - base), 32'd1);

        // Start together with abort in IDLE.
        start = 1'b1;
        abort = 1'b1;
        cyc(1);
        start = 1'b0;
        abort = 1'b0;
        check_eq("sa_busy", 32'(busy), 32'd0);
        check_eq("sa_valid", 32'(tx.valid), 32'd0);
        cyc(3);
        check_eq("sa_idle", 32'(busy), 32'd0);

        // Reset in the middle of SEND, then a fresh frame.
        salt = 8'h05;
        push_frame(8'h05);
        nbytes = 0;
        start = 1'b1;
        cyc(1);
        start = 1'b0;
        wait_bytes(3, 60);
        rst = 1'b1;
        cyc(1);
        rst = 1'b0;
        check_eq("mid_rst_busy", 32'(busy), 32'd0);
        check_eq("mid_rst_valid", 32'(tx.valid), 32'd0);
        check_eq("mid_rst_data", {24'h0, tx.data}, 32'd0);
        check_eq("mid_rst_done", 32'(done), 32'd0);
        check_eq("mid_rst_addr", 32'(pmu_addr), 32'd0);
        exp_q.delete();
        cyc(2);
        run_frame(8'h09, 200, 0);
        cyc(5);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
